ks_adder_pipe: RTL and testbench
================================

Name: ks_adder_pipe

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor; successor to the fixed 4-bit combinational prefix adder.
- Arbitrary WIDTH, carry-in treated as prefix position -1, and a programmable number of prefix levels per pipeline stage.
- Valid/ready handshake on both sides; sits in datapaths that need high-fmax wide adds at full throughput with backpressure.

Parameters:
- WIDTH, 16, operand/sum width in bits; legal range 2..64.
- STAGE_EVERY, 2, prefix levels per pipeline stage; legal range 1..L, where L = ceil(log2(WIDTH+1)).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (not-borrow when sub=1)
- sub  input  1  1: compute a + ~b + cin; 0: compute a + b + cin
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out

Behaviour:
- Structure:
  - Pre-process: p_i = a_i ^ b'_i, g_i = a_i & b'_i, where b' = sub ? ~b : b.
  - Position -1: p = 0, g = cin.
  - Kogge-Stone prefix over WIDTH+1 positions, L levels, black cells at span 2^k.
  - Post: sum_i = p_i ^ G_(i-1).
  - cout = g_(W-1) | (p_(W-1) & G_(W-2)).
- Pipeline:
  - Stage 0 registers p, g and the cin position.
  - The L prefix levels are grouped STAGE_EVERY per stage, with a register after each group.
  - The last group includes post-processing and drives the output registers.
  - Latency LAT = 1 + ceil(L / STAGE_EVERY) register stages. WIDTH=16, STAGE_EVERY=2: L=5, LAT=4. WIDTH=4, STAGE_EVERY=2: L=3, LAT=3.
- Handshake:
  - adv = out_ready | ~out_valid; in_ready = adv (combinational).
  - Accept on the rising edge where in_valid & in_ready.
  - Every stage has a valid bit. All stages shift together when adv=1 and hold all contents when adv=0 (global stall).
  - A result is visible LAT edges after acceptance, counting the accepting edge, when there is no stall.
  - With out_ready=1, throughput is 1 result per cycle.
  - Bubbles are not collapsed. A bubble stage shifts as valid=0.
- Stall:
  - While out_valid=1 and out_ready=0: sum, cout, out_valid and all internal stages hold.
  - in_ready=0 in this state, so no operand is lost or duplicated.
  - Transfer out occurs on the edge where out_valid & out_ready.
- Reset:
  - Asynchronous assert clears all stage valid bits.
  - out_valid=0, sum=0, cout=0; in_ready=1 while reset is held.
  - Reset mid-operation discards all in-flight operations; no partial result is emitted.
  - Deassertion is synchronised by the integrator. The block needs only glitch-free deassertion.
- Arithmetic:
  - Modulo 2^WIDTH; cout is bit WIDTH of the full result.
  - For sub=1, cin=1: result is a - b, and cout=1 means no borrow.
- Data registers may be non-reset. The outputs sum and cout must be reset.

Optional Feature:
- Macro KS_ADDER_PIPE_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit).
  - ovf = signed two's-complement overflow = carry into the MSB ^ cout, computed in the final stage.
  - ovf is registered alongside sum, stalls with it, and resets to 0.
- When undefined: the port is absent and no extra logic is built.

Test Plan:
- WIDTH=16, STAGE_EVERY=2. Accept a=0xFFFF, b=0x0001, cin=0, sub=0 at edge k -> out_valid=1 after edge k+3; sum=0x0000, cout=1.
- a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0. a=0x0007, b=0x0005, sub=1, cin=1 -> sum=0x0002, cout=1.
- Stream 8 back-to-back ops (a=i, b=0x1000*i, cin=i&1), out_ready=1 -> 8 consecutive out_valid cycles, in order. Each sum matches the reference model and in_ready stays 1.
- Fill the pipe, then drop out_ready for 3 cycles -> in_ready=0 and outputs frozen. On release, results resume in order with none dropped or duplicated.
- Assert rst_n=0 for 1 cycle with 3 ops in flight -> out_valid=0, sum=0, cout=0 immediately. No stale result appears after release.
- With KS_ADDER_PIPE_OVF_EN: 0x7FFF + 0x0001 -> ovf=1, sum=0x8000. 0xFFFF + 0x0001 -> ovf=0. Sweep WIDTH=4 exhaustively (512 cases incl. cin) against the reference model.

Source files
------------

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and global stall.
// Optional signed-overflow output when KS_ADDER_PIPE_OVF_EN is defined.
module ks_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int STAGE_EVERY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef KS_ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N    = WIDTH + 1;
    localparam int unsigned L    = $clog2(WIDTH + 1);
    localparam int unsigned SE   = STAGE_EVERY;
    localparam int unsigned NSTG = (L + SE - 1) / SE;

    logic             adv;
    logic [WIDTH-1:0] bx, p_pre, g_pre;
    logic [WIDTH-1:0] fsum;
    logic             fcout;

    // rg/rp[s] feed prefix group s; position 0 holds the carry-in
    logic [N-1:0]     rg  [NSTG];
    logic [N-1:0]     rp  [NSTG];
    logic [WIDTH-1:0] rpo [NSTG];
    logic [NSTG-1:0]  rv;

    logic [N-1:0]     cg [L];
    logic [N-1:0]     cp [L];
    logic [N-1:0]     tg, tp;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    assign bx    = sub ? ~b : b;
    assign p_pre = a ^ bx;
    assign g_pre = a & bx;

    // Each level reads a pipeline register at the start of its group, else the previous level
    always_comb begin
        cg = '{default: '0};
        cp = '{default: '0};
        tg = '0;
        tp = '0;
        for (int unsigned k = 0; k < L; k++) begin
            if (k % SE == 0) begin
                tg = rg[k / SE];
                tp = rp[k / SE];
            end else begin
                tg = cg[k - 1];
                tp = cp[k - 1];
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (i >= (32'd1 << k)) begin
                    cg[k][i] = tg[i] | (tp[i] & tg[i - (32'd1 << k)]);
                    cp[k][i] = tp[i] & tp[i - (32'd1 << k)];
                end else begin
                    cg[k][i] = tg[i];
                    cp[k][i] = tp[i];
                end
            end
        end
    end

    assign fsum  = rpo[NSTG-1] ^ cg[L-1][WIDTH-1:0];
    assign fcout = cg[L-1][WIDTH];

    always_ff @(posedge clk) begin
        if (adv) begin
            rg[0]  <= {g_pre, cin};
            rp[0]  <= {p_pre, 1'b0};
            rpo[0] <= p_pre;
            for (int unsigned s = 1; s < NSTG; s++) begin
                rg[s]  <= cg[s * SE - 1];
                rp[s]  <= cp[s * SE - 1];
                rpo[s] <= rpo[s - 1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv        <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef KS_ADDER_PIPE_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (adv) begin
            rv[0] <= in_valid;
            for (int unsigned s = 1; s < NSTG; s++) begin
                rv[s] <= rv[s - 1];
            end
            out_valid <= rv[NSTG-1];
            sum       <= fsum;
            cout      <= fcout;
`ifdef KS_ADDER_PIPE_OVF_EN
            ovf       <= cg[L-1][WIDTH] ^ cg[L-1][WIDTH-1];
`endif
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: 16-bit directed/stream/stall/reset tests plus 4-bit exhaustive sweep.
module tb_ks_adder_pipe;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [W-1:0] a, b, sum;
    logic         iv4, ir4, ci4, sb4, ov4, or4, co4;
    logic [3:0]   a4, b4, s4;
`ifdef KS_ADDER_PIPE_OVF_EN
    logic         ovf, ovf4;
`endif

    ks_adder_pipe #(.WIDTH(W), .STAGE_EVERY(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef KS_ADDER_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    ks_adder_pipe #(.WIDTH(4), .STAGE_EVERY(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(ci4), .sub(sb4), .out_valid(ov4),
        .out_ready(or4), .sum(s4), .cout(co4)
`ifdef KS_ADDER_PIPE_OVF_EN
        , .ovf(ovf4)
`endif
    );

    typedef struct { logic [W-1:0] s; logic c; logic o; } exp_t;
    typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic cin; logic sub; exp_t e; } vec_t;
    typedef struct { logic [3:0] s; logic c; logic o; } exp4_t;

    exp_t  q[$];
    exp4_t q4[$];
    vec_t  tbl [7];
    int    checks = 0;
    int    errors = 0;
    int    nxfer  = 0;
    logic  seen;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
        logic [W-1:0] yb;
        logic [W:0]   full;
        exp_t         e;
        yb   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, c};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (x[W-1] == yb[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    function automatic exp4_t model4(input logic [3:0] x, input logic [3:0] y, input logic c, input logic s);
        logic [3:0] yb;
        logic [4:0] full;
        exp4_t      e;
        yb   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yb} + {4'b0, c};
        e.s  = full[3:0];
        e.c  = full[4];
        e.o  = (x[3] == yb[3]) && (full[3] != x[3]);
        return e;
    endfunction

    // Inputs change on the falling edge; outputs sampled 1 time unit later, before the next rising edge
    task automatic step(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s, input logic ordy, input exp_t e);
        exp_t f;
        @(negedge clk);
        in_valid = v; a = x; b = y; cin = c; sub = s; out_ready = ordy;
        #1;
        seen = out_valid;
        if (out_valid && out_ready) begin
            nxfer++;
            chk("queue_nonempty", {63'd0, q.size() != 0}, 64'd1);
            if (q.size() != 0) begin
                f = q.pop_front();
                chk("sum", {48'd0, sum}, {48'd0, f.s});
                chk("cout", {63'd0, cout}, {63'd0, f.c});
`ifdef KS_ADDER_PIPE_OVF_EN
                chk("ovf", {63'd0, ovf}, {63'd0, f.o});
`endif
            end
        end
        if (in_valid && in_ready) q.push_back(e);
    endtask

    task automatic idle(input logic ordy);
        exp_t z;
        z = '{'0, 1'b0, 1'b0};
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy, z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] xa, xb;
        exp_t         e;
        exp4_t        f4;
        int           n, first, last, x0, n0;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
        tbl[1] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
        tbl[2] = '{16'h0007, 16'h0005, 1'b1, 1'b1, '{16'h0002, 1'b1, 1'b0}};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0}};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv4 = 1'b0; or4 = 1'b1; a4 = '0; b4 = '0; ci4 = 1'b0; sb4 = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {48'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Latency: accepting edge plus three more
        step(1'b1, tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].sub, 1'b1, tbl[0].e);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            idle(1'b1);
            if (seen) begin
                n = i;
                break;
            end
        end
        chk("latency", 64'(n), 64'd4);
        idle(1'b1);

        // Directed table, back to back
        for (int i = 0; i < 7; i++)
            step(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, tbl[i].e);
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
        chk("table_drained", 64'(q.size()), 64'd0);

        // Stream of 8 with full throughput
        x0 = nxfer; first = -1; last = -1;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) begin
                xa = W'(i); xb = W'(i * 4096);
                step(1'b1, xa, xb, i[0], 1'b0, 1'b1, model(xa, xb, i[0], 1'b0));
                chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            end else begin
                idle(1'b1);
            end
            if (seen) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("stream_count", 64'(nxfer - x0), 64'd8);
        chk("stream_contig", 64'(last - first + 1), 64'd8);

        // Fill the pipe, then stall for three cycles
        for (int i = 0; i < 6; i++) begin
            xa = W'($urandom); xb = W'($urandom);
            step(1'b1, xa, xb, xa[0], xb[0], 1'b1, model(xa, xb, xa[0], xb[0]));
        end
        for (int i = 0; i < 3; i++) begin
            xa = W'($urandom); xb = W'($urandom);
            step(1'b1, xa, xb, 1'b0, 1'b0, 1'b0, model(xa, xb, 1'b0, 1'b0));
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_sum", {48'd0, sum}, {48'd0, q[0].s});
            chk("stall_cout", {63'd0, cout}, {63'd0, q[0].c});
        end
        n0 = q.size(); x0 = nxfer;
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
        chk("stall_drain_count", 64'(nxfer - x0), 64'(n0));
        chk("stall_drained", 64'(q.size()), 64'd0);

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            xa = W'($urandom); xb = W'($urandom);
            step(1'b1, xa, xb, 1'b0, 1'b0, 1'b1, model(xa, xb, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_sum", {48'd0, sum}, 64'd0);
        chk("midrst_cout", {63'd0, cout}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            chk("no_stale", {63'd0, out_valid}, 64'd0);
        end

        // Exhaustive 4-bit sweep, streaming
        for (int i = 0; i < 540; i++) begin
            @(negedge clk);
            iv4 = (i < 512);
            a4 = i[3:0]; b4 = i[7:4]; ci4 = i[8]; sb4 = i[0] ^ i[5];
            #1;
            if (ov4) begin
                chk("w4_queue_nonempty", {63'd0, q4.size() != 0}, 64'd1);
                if (q4.size() != 0) begin
                    f4 = q4.pop_front();
                    chk("w4_sum", {60'd0, s4}, {60'd0, f4.s});
                    chk("w4_cout", {63'd0, co4}, {63'd0, f4.c});
`ifdef KS_ADDER_PIPE_OVF_EN
                    chk("w4_ovf", {63'd0, ovf4}, {63'd0, f4.o});
`endif
                end
            end
            if (iv4 && ir4) q4.push_back(model4(a4, b4, ci4, sb4));
        end
        chk("w4_drained", 64'(q4.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
